// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef logic idx_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side bus of mem_arb; slave = arbiter, master = requesters/memory.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          mem_ce;
    logic          mem_sel;
    logic          mem_pwrite;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt, rvalid, rdata, mem_ce, mem_sel, mem_pwrite, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt, rvalid, rdata, mem_ce, mem_sel, mem_pwrite, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester grant decision; MEM_ARB_RR_EN selects round-robin, otherwise fixed priority to 0.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        gnt = req;
        if (&req) gnt = ptr ? 2'b10 : 2'b01;
    end
`else
    logic ptr_unused;
    assign ptr_unused = ptr;

    always_comb begin
        gnt = req;
        if (req[0]) gnt = 2'b01;
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-port single-outstanding memory arbiter: IDLE grants, ISSUE strobes memory, RESP returns.
// Policy via MEM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    state_t        state;
    state_t        state_nx;
    idx_t          owner;
    idx_t          win;
    logic          ptr;
    logic          take;
    logic [1:0]    arb_gnt;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= 1'b0;
        else if (take) ptr <= ~win;
    end
`else
    assign ptr = 1'b0;
`endif

    rr_arb2 u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // gnt is combinational in IDLE, so it is gated by rst to stay quiet during reset
    assign take      = (state == IDLE) && (|bus.req) && !rst;
    assign win       = arb_gnt[1];
    assign addr_sel  = win ? bus.addr1  : bus.addr0;
    assign wdata_sel = win ? bus.wdata1 : bus.wdata0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = ISSUE;
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner          <= 1'b0;
            bus.mem_pwrite <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else if (take) begin
            owner          <= win;
            bus.mem_pwrite <= bus.we[win];
            bus.mem_addr   <= addr_sel;
            bus.mem_wdata  <= wdata_sel;
        end
    end

    always_comb begin
        bus.gnt     = take ? arb_gnt : 2'b00;
        bus.mem_ce  = (state == ISSUE);
        bus.mem_sel = (state != ISSUE);
        bus.rvalid  = 2'b00;
        bus.rdata   = '0;
        if (state == RESP) begin
            bus.rvalid[owner] = 1'b1;
            if (!bus.mem_pwrite) bus.rdata = bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with a registered 256x32 memory model.
module tb_mem_arb;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [1:0]  expg;
    logic [31:0] mem [256];

    mem_arb_if #(.AW(8), .DW(32)) bus ();

    mem_arb #(.AW(8), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory returns read data on the edge after the access edge
    always @(posedge clk) begin
        if (bus.mem_ce && !bus.mem_sel) begin
            if (bus.mem_pwrite) mem[bus.mem_addr] <= bus.mem_wdata;
            else                bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt();
        int n = 0;
        #1;
        while (bus.gnt == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic txn(input int unsigned i, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input string tag);
        logic [1:0] oh;
        oh = (i == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        bus.req[i] = 1'b1;
        bus.we[i]  = w;
        if (i == 0) begin bus.addr0 = a; bus.wdata0 = w ? d : 32'h0; end
        else        begin bus.addr1 = a; bus.wdata1 = w ? d : 32'h0; end
        wait_gnt();
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
        check({tag, ".rvalid_at_gnt"}, 32'(bus.rvalid), 32'h0);
        @(negedge clk);
        bus.req[i] = 1'b0;
        #1;
        check({tag, ".mem_ce"}, 32'(bus.mem_ce), 32'h1);
        check({tag, ".mem_sel"}, 32'(bus.mem_sel), 32'h0);
        check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(a));
        check({tag, ".mem_pwrite"}, 32'(bus.mem_pwrite), 32'(w));
        if (w) check({tag, ".mem_wdata"}, bus.mem_wdata, d);
        @(negedge clk);
        #1;
        check({tag, ".rvalid"}, 32'(bus.rvalid), 32'(oh));
        check({tag, ".rdata"}, bus.rdata, w ? 32'h0 : d);
        check({tag, ".mem_ce_off"}, 32'(bus.mem_ce), 32'h0);
        @(negedge clk);
        #1;
        check({tag, ".rvalid_off"}, 32'(bus.rvalid), 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int unsigned k = 0; k < 256; k++) mem[k] = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.req = 2'b00; bus.we = 2'b00;
        bus.addr0 = 8'h0; bus.addr1 = 8'h0;
        bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
        rst = 1'b1;

        // reset values, with requests pending to show gnt stays low
        repeat (2) @(negedge clk);
        bus.req = 2'b11;
        #1;
        check("rst.gnt", 32'(bus.gnt), 32'h0);
        check("rst.rvalid", 32'(bus.rvalid), 32'h0);
        check("rst.rdata", bus.rdata, 32'h0);
        check("rst.mem_ce", 32'(bus.mem_ce), 32'h0);
        check("rst.mem_sel", 32'(bus.mem_sel), 32'h1);
        check("rst.mem_pwrite", 32'(bus.mem_pwrite), 32'h0);
        check("rst.mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst.mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        bus.req = 2'b00;
        rst = 1'b0;

        // write then read back through port 0, then port 1 at the top address
        txn(0, 1'b1, 8'h05, 32'hDEADBEEF, "wr0");
        txn(0, 1'b0, 8'h05, 32'hDEADBEEF, "rd0");
        txn(1, 1'b1, 8'hFF, 32'h12345678, "wr1");
        txn(1, 1'b0, 8'hFF, 32'h12345678, "rd1");

        // short req0 pulse confined to RESP of a port-1 read
        @(negedge clk);
        bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.addr1 = 8'hFF;
        #1;
        check("pulse.gnt1", 32'(bus.gnt), 32'h2);
        @(negedge clk);
        bus.req[1] = 1'b0;
        @(negedge clk);
        bus.req[0] = 1'b1; bus.we[0] = 1'b0; bus.addr0 = 8'h05;
        #1;
        check("pulse.rvalid1", 32'(bus.rvalid), 32'h2);
        check("pulse.gnt_in_resp", 32'(bus.gnt), 32'h0);
        @(posedge clk);
        bus.req[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("pulse.idle_gnt", 32'(bus.gnt), 32'h0);
            check("pulse.idle_ce", 32'(bus.mem_ce), 32'h0);
            check("pulse.idle_rvalid", 32'(bus.rvalid), 32'h0);
        end

        // reset in ISSUE aborts the transaction
        @(negedge clk);
        bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 32'hA5A5A5A5;
        #1;
        check("abort.gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        bus.req[0] = 1'b0;
        #1;
        check("abort.ce_before", 32'(bus.mem_ce), 32'h1);
        rst = 1'b1;
        #1;
        check("abort.mem_ce", 32'(bus.mem_ce), 32'h0);
        check("abort.mem_sel", 32'(bus.mem_sel), 32'h1);
        check("abort.mem_addr", 32'(bus.mem_addr), 32'h0);
        check("abort.mem_wdata", bus.mem_wdata, 32'h0);
        check("abort.mem_pwrite", 32'(bus.mem_pwrite), 32'h0);
        check("abort.gnt_rst", 32'(bus.gnt), 32'h0);
        check("abort.rdata", bus.rdata, 32'h0);
        @(negedge clk);
        bus.req[1] = 1'b1; bus.we[1] = 1'b0; bus.addr1 = 8'hFF;
        #1;
        check("abort.no_rvalid", 32'(bus.rvalid), 32'h0);
        check("abort.gnt_held", 32'(bus.gnt), 32'h0);
        check("abort.mem10_untouched", mem[8'h10], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst.first_gnt", 32'(bus.gnt), 32'h2);
        @(negedge clk);
        bus.req[1] = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst.rvalid", 32'(bus.rvalid), 32'h2);
        check("post_rst.rdata", bus.rdata, 32'h12345678);

        // both requesters held high
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.we = 2'b00; bus.addr0 = 8'h05; bus.addr1 = 8'hFF;
                bus.req = 2'b11;
            end
            wait_gnt();
`ifdef MEM_ARB_RR_EN
            expg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            expg = 2'b01;
`endif
            check("both.gnt", 32'(bus.gnt), 32'(expg));
            @(negedge clk);
            @(negedge clk);
            #1;
            check("both.rvalid", 32'(bus.rvalid), 32'(expg));
            check("both.rdata", bus.rdata, (expg == 2'b01) ? 32'hDEADBEEF : 32'h12345678);
        end
        bus.req = 2'b00;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
